// File: rtl/wb_pkg.sv
// Shared types and default source-index map for the register-file write-back stage.
package wb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wb_state_t;

  localparam int WB_SRC_ALU  = 0;
  localparam int WB_SRC_MEM  = 1;
  localparam int WB_SRC_LINK = 2;
  localparam int WB_SRC_IMM  = 3;

  // Select-index width; a single-source build still needs a 1-bit select port.
  function automatic int wb_sel_w(input int nsrc);
    return (nsrc > 1) ? $clog2(nsrc) : 1;
  endfunction

endpackage

// File: rtl/wb_src_mux.sv
// Combinational NSRC:1 result select over a packed source bus, flagging out-of-range indices.
module wb_src_mux
  import wb_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int NSRC  = 4,
  localparam int SEL_W = wb_sel_w(NSRC)
) (
  input  logic [NSRC*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]      sel_i,
  output logic [WIDTH-1:0]      data_o,
  output logic                  sel_oob_o
);

  always_comb begin
    data_o    = '0;
    sel_oob_o = (int'(sel_i) >= NSRC);
    for (int i = 0; i < NSRC; i++) begin
      if (int'(sel_i) == i) begin
        data_o = data_i[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Register-file write-back stage: selects the retiring result, defers memory-sourced
// results until read data arrives or a timeout expires, and drives a registered write strobe.
module writeback_stage
  import wb_pkg::*;
#(
  parameter  int WIDTH       = 16,
  parameter  int NSRC        = 4,
  parameter  int MEM_SRC     = WB_SRC_MEM,
  parameter  int RADDR_W     = 4,
  parameter  int MEM_TIMEOUT = 15,
  localparam int SEL_W       = wb_sel_w(NSRC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic [RADDR_W-1:0]    in_dest,
  input  logic [NSRC*WIDTH-1:0] in_data,
  input  logic                  mem_rvalid,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic                  rf_we,
  output logic [RADDR_W-1:0]    rf_waddr,
  output logic [WIDTH-1:0]      rf_wdata,
  output logic                  busy,
  output logic                  err_sel,
  output logic                  err_timeout
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  wb_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RADDR_W-1:0] dest_q, dest_d;
  logic               rf_we_q, rf_we_d;
  logic [RADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [WIDTH-1:0]   rf_wdata_q, rf_wdata_d;
  logic               err_sel_q, err_sel_d;
  logic               err_to_q, err_to_d;

  logic [WIDTH-1:0]   mux_data;
  logic               mux_oob;
  logic               xfer;

  wb_src_mux #(
    .WIDTH (WIDTH),
    .NSRC  (NSRC)
  ) u_mux (
    .data_i    (in_data),
    .sel_i     (in_sel),
    .data_o    (mux_data),
    .sel_oob_o (mux_oob)
  );

  assign in_ready = (state_q == IDLE);
  assign xfer     = in_valid & in_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dest_d     = dest_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    err_sel_d  = 1'b0;
    err_to_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          if (mux_oob) begin
            err_sel_d = 1'b1;
          end else if (int'(in_sel) == MEM_SRC) begin
            dest_d  = in_dest;
            cnt_d   = '0;
            state_d = WAIT;
          end else begin
            rf_we_d    = 1'b1;
            rf_waddr_d = in_dest;
            rf_wdata_d = mux_data;
          end
        end
      end
      WAIT: begin
        // Read data arriving on the last counting cycle still beats the timeout.
        if (mem_rvalid) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = dest_q;
          rf_wdata_d = mem_rdata;
          state_d    = IDLE;
        end else if (int'(cnt_q) == MEM_TIMEOUT - 1) begin
          err_to_d = 1'b1;
          state_d  = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dest_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      err_sel_q  <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dest_q     <= dest_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      err_sel_q  <= err_sel_d;
      err_to_q   <= err_to_d;
    end
  end

  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign busy        = (state_q == WAIT);
  assign err_sel     = err_sel_q;
  assign err_timeout = err_to_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: scoreboarded register-file writes plus handshake/error checks.
module tb_writeback_stage;

  localparam int WIDTH = 16;
  localparam int TMO   = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  // Main instance: NSRC=4
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_sel = '0;
  logic [3:0]  in_dest = '0;
  logic [63:0] in_data = '0;
  logic        mem_rvalid = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        busy, err_sel, err_timeout;

  // Second instance: NSRC=3 so in_sel=3 is out of range
  logic        in_valid3 = 1'b0;
  logic        in_ready3;
  logic [1:0]  in_sel3 = '0;
  logic [3:0]  in_dest3 = '0;
  logic [47:0] in_data3 = '0;
  logic        rf_we3;
  logic [3:0]  rf_waddr3;
  logic [15:0] rf_wdata3;
  logic        busy3, err_sel3, err_timeout3;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  writeback_stage #(.WIDTH(WIDTH), .NSRC(4), .MEM_SRC(1), .RADDR_W(4), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_dest(in_dest), .in_data(in_data), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy),
    .err_sel(err_sel), .err_timeout(err_timeout)
  );

  writeback_stage #(.WIDTH(WIDTH), .NSRC(3), .MEM_SRC(1), .RADDR_W(4), .MEM_TIMEOUT(TMO)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .in_sel(in_sel3),
    .in_dest(in_dest3), .in_data(in_data3), .mem_rvalid(1'b0), .mem_rdata(16'h0000),
    .rf_we(rf_we3), .rf_waddr(rf_waddr3), .rf_wdata(rf_wdata3), .busy(busy3),
    .err_sel(err_sel3), .err_timeout(err_timeout3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Every write the main instance issues must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {rf_waddr, rf_wdata}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(rf_waddr), 32'(e.addr));
        chk("wr_data", 32'(rf_wdata), 32'(e.data));
      end
    end
  end

  task automatic drive(input logic [1:0] sel, input logic [3:0] dest, input logic [15:0] d);
    in_valid = 1'b1;
    in_sel   = sel;
    in_dest  = dest;
    in_data  = {16'hA5A5, 16'h5A5A, 16'hDEAD, 16'h0F0F};
    in_data[sel*16 +: 16] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Asynchronous reset with no clock edge yet
    #3 rst = 1'b1;
    #1;
    chk("rst_we", 32'(rf_we), 0);
    chk("rst_waddr", 32'(rf_waddr), 0);
    chk("rst_wdata", 32'(rf_wdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_errs", {err_sel, err_timeout}, 0);
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 1);

    // Back-to-back ALU, immediate, link (address 0 is an ordinary target)
    step();
    drive(2'd0, 4'd3, 16'h1234); exp_q.push_back('{4'd3, 16'h1234});
    step();
    drive(2'd3, 4'd5, 16'hBEEF); exp_q.push_back('{4'd5, 16'hBEEF});
    @(negedge clk); chk("b2b_we0", 32'(rf_we), 1);
    step();
    drive(2'd2, 4'd0, 16'h0042); exp_q.push_back('{4'd0, 16'h0042});
    @(negedge clk); chk("b2b_we1", 32'(rf_we), 1);
    step();
    in_valid = 1'b0;
    @(negedge clk); chk("b2b_we2", 32'(rf_we), 1); chk("b2b_ready", 32'(in_ready), 1);
    @(negedge clk); chk("b2b_idle_we", 32'(rf_we), 0);

    // mem_rvalid in IDLE is ignored (monitor flags any write)
    step(); mem_rvalid = 1'b1; mem_rdata = 16'h7777;
    step(); mem_rvalid = 1'b0;
    @(negedge clk); chk("idle_rvalid_we", 32'(rf_we), 0);

    // Memory load: rvalid on the 4th WAIT cycle
    drive(2'd1, 4'd7, 16'h1111);
    step();
    in_valid = 1'b0; in_dest = 4'hF;
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) begin
        mem_rvalid = 1'b1; mem_rdata = 16'hCAFE; exp_q.push_back('{4'd7, 16'hCAFE});
      end
      @(negedge clk);
      chk("ld_busy", 32'(busy), 1);
      chk("ld_ready", 32'(in_ready), 0);
      chk("ld_we", 32'(rf_we), 0);
      step();
      mem_rvalid = 1'b0;
    end
    @(negedge clk);
    chk("ld_wr_we", 32'(rf_we), 1);
    chk("ld_wr_ready", 32'(in_ready), 1);
    chk("ld_wr_busy", 32'(busy), 0);

    // Timeout: no rvalid at all
    step();
    drive(2'd1, 4'd9, 16'h0000);
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      chk("to_busy", 32'(busy), 1);
      chk("to_early_err", 32'(err_timeout), 0);
      step();
    end
    @(negedge clk);
    chk("to_err", 32'(err_timeout), 1);
    chk("to_we", 32'(rf_we), 0);
    chk("to_ready", 32'(in_ready), 1);
    @(negedge clk);
    chk("to_err_pulse", 32'(err_timeout), 0);

    // rvalid on the final counting cycle wins over the timeout
    step();
    drive(2'd1, 4'd10, 16'h0000);
    step();
    in_valid = 1'b0;
    for (int k = 1; k < TMO; k++) step();
    mem_rvalid = 1'b1; mem_rdata = 16'h5A5A; exp_q.push_back('{4'd10, 16'h5A5A});
    @(negedge clk); chk("race_busy", 32'(busy), 1);
    step();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("race_we", 32'(rf_we), 1);
    chk("race_err", 32'(err_timeout), 0);
    chk("race_ready", 32'(in_ready), 1);

    // Bad select on the NSRC=3 build, then a legal link write on it
    step();
    in_valid3 = 1'b1; in_sel3 = 2'd3; in_dest3 = 4'd6; in_data3 = 48'h3333_2222_1111;
    step();
    in_sel3 = 2'd2; in_dest3 = 4'd8;
    @(negedge clk);
    chk("oob_err", 32'(err_sel3), 1);
    chk("oob_we", 32'(rf_we3), 0);
    chk("oob_ready", 32'(in_ready3), 1);
    step();
    in_valid3 = 1'b0;
    @(negedge clk);
    chk("n3_err_pulse", 32'(err_sel3), 0);
    chk("n3_we", 32'(rf_we3), 1);
    chk("n3_wr", {rf_waddr3, rf_wdata3}, {12'h0, 4'd8, 16'h3333});

    // Reset mid-WAIT drops the pending load
    step();
    drive(2'd1, 4'd2, 16'h0000);
    step();
    in_valid = 1'b0;
    step(); step();
    #2 rst = 1'b1;
    #1;
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_waddr", 32'(rf_waddr), 0);
    chk("mrst_wdata", 32'(rf_wdata), 0);
    step();
    rst = 1'b0;
    step();
    mem_rvalid = 1'b1; mem_rdata = 16'h9999;
    step();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("mrst_we", 32'(rf_we), 0);
    chk("mrst_err", {err_sel, err_timeout}, 0);
    chk("mrst_ready", 32'(in_ready), 1);
    step(); step();

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
